// File: rtl/program_counter_if.sv
// rtl/program_counter_if.sv - fetch-address bus between the IF next-address mux and the PC
interface program_counter_if #(
    parameter int WIDTH = 16
);
    logic             PCWrite;
    logic [WIDTH-1:0] address_in;
    logic [WIDTH-1:0] address_out;
    logic [WIDTH-1:0] address_inc;

    modport master (
        output PCWrite,
        output address_in,
        input  address_out,
        input  address_inc
    );

    modport slave (
        input  PCWrite,
        input  address_in,
        output address_out,
        output address_inc
    );
endinterface

// File: rtl/program_counter.sv
// rtl/program_counter.sv - IF-stage program counter with stall hold and sequential increment
module program_counter #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INCR         = 2
) (
    input  logic              clk,
    input  logic              reset,
    program_counter_if.slave  pc_bus
);
    localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

    logic [WIDTH-1:0] pc;

    // PCWrite low is a hazard stall: pc simply holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_VECTOR;
        end else if (pc_bus.PCWrite) begin
            pc <= pc_bus.address_in;
        end
    end

    assign pc_bus.address_out = pc;
    assign pc_bus.address_inc = pc + INCR_W;
endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - randomized self-checking bench for program_counter
module tb_program_counter;
    localparam int RV  = 0;
    localparam int INC = 2;

    logic clk;
    logic reset;
    program_counter_if #(.WIDTH(16)) bus ();

    program_counter #(
        .WIDTH       (16),
        .RESET_VECTOR(16'h0000),
        .INCR        (INC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pc_bus(bus.slave)
    );

    int model;
    int n_checks;
    int n_pass;

    // One full clock period; the model loads on the rising edge exactly as an architectural PC would.
    task automatic tick();
        clk = 1'b1;
        if (reset === 1'b1 && bus.PCWrite === 1'b1) model = int'(bus.address_in);
        #5;
        clk = 1'b0;
        #5;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.PCWrite = 1'b1;
        bus.address_in = 16'h0000;
        #1;
        model = RV;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.address_out !== 16'h0000) $display("FAIL reset_out[%0d]: got %h want 0000", i, bus.address_out);
            else n_pass++;
            n_checks++;
            if (bus.address_inc !== 16'h0002) $display("FAIL reset_inc[%0d]: got %h want 0002", i, bus.address_inc);
            else n_pass++;
        end
        reset = 1'b1;
        #2;
        tick();
        n_checks++;
        if (bus.address_out !== 16'(model)) $display("FAIL reset_release: got %h want %h", bus.address_out, 16'(model));
        else n_pass++;
    endtask

    task automatic test_load_hold();
        bus.PCWrite = 1'b1;
        bus.address_in = 16'h0011;
        #2;
        n_checks++;
        if (bus.address_out !== 16'(model)) $display("FAIL no_comb_path: got %h want %h", bus.address_out, 16'(model));
        else n_pass++;
        bus.address_in = 16'h01C1;
        tick();
        n_checks++;
        if (bus.address_out !== 16'h01C1) $display("FAIL load_out: got %h want 01C1", bus.address_out);
        else n_pass++;
        n_checks++;
        if (bus.address_inc !== 16'h01C3) $display("FAIL load_inc: got %h want 01C3", bus.address_inc);
        else n_pass++;
    endtask

    task automatic test_stall();
        bus.PCWrite = 1'b0;
        bus.address_in = 16'h0FF1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (bus.address_out !== 16'h01C1) $display("FAIL stall[%0d]: got %h want 01C1", i, bus.address_out);
            else n_pass++;
        end
        bus.PCWrite = 1'b1;
        tick();
        n_checks++;
        if (bus.address_out !== 16'h0FF1) $display("FAIL stall_release: got %h want 0FF1", bus.address_out);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bus.PCWrite = 1'b0;
        clk = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        model = RV;
        n_checks++;
        if (bus.address_out !== 16'h0000) $display("FAIL async_out: got %h want 0000", bus.address_out);
        else n_pass++;
        n_checks++;
        if (bus.address_inc !== 16'h0002) $display("FAIL async_inc: got %h want 0002", bus.address_inc);
        else n_pass++;
        #2;
        clk = 1'b0;
        bus.PCWrite = 1'b1;
        bus.address_in = 16'h1234;
        #5;
        tick();
        n_checks++;
        if (bus.address_out !== 16'h0000) $display("FAIL reset_beats_edge: got %h want 0000", bus.address_out);
        else n_pass++;
        reset = 1'b1;
        #3;
    endtask

    task automatic test_wrap();
        logic [15:0] vals [3];
        vals[0] = 16'hFFFE;
        vals[1] = 16'hFFFF;
        vals[2] = 16'h0001;
        bus.PCWrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.address_in = vals[i];
            tick();
            n_checks++;
            if (bus.address_out !== vals[i]) $display("FAIL wrap_out[%0d]: got %h want %h", i, bus.address_out, vals[i]);
            else n_pass++;
            n_checks++;
            if (bus.address_inc !== 16'((int'(vals[i]) + INC) % 65536))
                $display("FAIL wrap_inc[%0d]: got %h want %h", i, bus.address_inc, 16'((int'(vals[i]) + INC) % 65536));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        vals[0] = 16'h0002;
        vals[1] = 16'h0004;
        vals[2] = 16'h0100;
        bus.PCWrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.address_in = vals[i];
            tick();
            n_checks++;
            if (bus.address_out !== vals[i]) $display("FAIL b2b[%0d]: got %h want %h", i, bus.address_out, vals[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.PCWrite = 1'($urandom_range(0, 1));
            bus.address_in = 16'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b0;
                #1;
                model = RV;
                reset = 1'b1;
                #1;
            end
            tick();
            // Mid-cycle input churn must not reach the outputs.
            bus.address_in = 16'($urandom);
            bus.PCWrite = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (bus.address_out !== 16'(model)) $display("FAIL rand_out[%0d]: got %h want %h", i, bus.address_out, 16'(model));
            else n_pass++;
            n_checks++;
            if (bus.address_inc !== 16'((model + INC) % 65536))
                $display("FAIL rand_inc[%0d]: got %h want %h", i, bus.address_inc, 16'((model + INC) % 65536));
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        model = RV;
        clk = 1'b0;
        reset = 1'b1;
        bus.PCWrite = 1'b0;
        bus.address_in = 16'h0000;
        #3;
        test_reset();
        test_load_hold();
        test_stall();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
